// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges in-order WB results and a FIFO of multi-cycle
// results onto the single register-file write port through a registered
// output stage, and reports in-flight destinations for decode stalls.
// Optional WB_FAIR_ARB_EN: starvation counter forces a FIFO drain after
// MAX_STARVE consecutive WB wins while the FIFO waits.
module rf_writeback_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CW         = 3,
  parameter int unsigned MAX_STARVE = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [4:0]    wb_wr,
  input  logic [31:0]   wb_wd,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_wr,
  input  logic [31:0]   md_wd,
  output logic          rf_write,
  output logic [4:0]    rf_wr,
  output logic [31:0]   rf_wd,
  input  logic [4:0]    q1,
  input  logic [4:0]    q2,
  output logic          q1_pend,
  output logic          q2_pend,
  output logic [CW-1:0] fifo_count,
  output logic          wb_stall
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [4:0]       fifo_wr [DEPTH];
  logic [31:0]      fifo_wd [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             wb_valid;
  logic             push;
  logic             pop;

  // Handshake and arbitration decisions from current state and inputs
  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == CW'(DEPTH));
    md_ready   = !reset && !fifo_full;
    push       = md_valid && md_ready && (md_wr != '0);
    wb_valid   = wb_we && (wb_wr != '0) && !wb_stall;
    // a forced drain shows up here as wb_valid=0 with a non-empty FIFO
    pop        = !wb_valid && !fifo_empty;
  end

  // FIFO payload storage; contents are qualified by fifo_vld
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr] <= md_wr;
      fifo_wd[wr_ptr] <= md_wd;
    end
  end

  // FIFO pointers, occupancy and per-entry valid flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      fifo_vld   <= '0;
    end else begin
      if (push) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered write-port stage; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_wr    <= '0;
      rf_wd    <= '0;
    end else if (wb_valid) begin
      rf_write <= 1'b1;
      rf_wr    <= wb_wr;
      rf_wd    <= wb_wd;
    end else if (pop) begin
      rf_write <= 1'b1;
      rf_wr    <= fifo_wr[rd_ptr];
      rf_wd    <= fifo_wd[rd_ptr];
    end else begin
      rf_write <= 1'b0;
    end
  end

  // Pending-write scoreboard over queued entries and the staged write
  always_comb begin
    q1_pend = 1'b0;
    q2_pend = 1'b0;
    if (rf_write) begin
      if (rf_wr == q1) q1_pend = 1'b1;
      if (rf_wr == q2) q2_pend = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) begin
        if (fifo_wr[i] == q1) q1_pend = 1'b1;
        if (fifo_wr[i] == q2) q2_pend = 1'b1;
      end
    end
    if (q1 == '0) q1_pend = 1'b0;
    if (q2 == '0) q2_pend = 1'b0;
  end

`ifdef WB_FAIR_ARB_EN
  localparam int unsigned SW = $clog2(MAX_STARVE + 1);

  logic [SW-1:0] starve_cnt;

  assign wb_stall = (starve_cnt == SW'(MAX_STARVE));

  // Count consecutive WB wins that leave a waiting FIFO unserved
  always_ff @(posedge clk) begin
    if (reset || pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (wb_valid) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  logic unused_max_starve;

  assign wb_stall          = 1'b0;
  assign unused_max_starve = ^MAX_STARVE;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios followed
// by random traffic, compared every cycle against a queue-based model.
module tb_rf_writeback_arbiter;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned CW         = 3;
  localparam int unsigned MAX_STARVE = 8;
`ifdef WB_FAIR_ARB_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_we;
  logic [4:0]    wb_wr;
  logic [31:0]   wb_wd;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_wr;
  logic [31:0]   md_wd;
  logic          rf_write;
  logic [4:0]    rf_wr;
  logic [31:0]   rf_wd;
  logic [4:0]    q1;
  logic [4:0]    q2;
  logic          q1_pend;
  logic          q2_pend;
  logic [CW-1:0] fifo_count;
  logic          wb_stall;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(
    .DEPTH(DEPTH),
    .CW(CW),
    .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb_we(wb_we),
    .wb_wr(wb_wr),
    .wb_wd(wb_wd),
    .md_valid(md_valid),
    .md_ready(md_ready),
    .md_wr(md_wr),
    .md_wd(md_wd),
    .rf_write(rf_write),
    .rf_wr(rf_wr),
    .rf_wd(rf_wd),
    .q1(q1),
    .q2(q2),
    .q1_pend(q1_pend),
    .q2_pend(q2_pend),
    .fifo_count(fifo_count),
    .wb_stall(wb_stall)
  );

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wd;
  } ent_t;

  // reference model state
  ent_t        mq[$];
  logic        m_write = 1'b0;
  logic [4:0]  m_wr    = '0;
  logic [31:0] m_wd    = '0;
  int unsigned m_scnt  = 0;

  int ncomp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncomp++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic m_pend(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (m_write && m_wr == q) return 1'b1;
    foreach (mq[i]) if (mq[i].wr == q) return 1'b1;
    return 1'b0;
  endfunction

  // one clock cycle: drive, check against model, advance model
  task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic mv, input logic [4:0] mwr,
                      input logic [31:0] mwd, input logic [4:0] a, input logic [4:0] b);
    logic e_stall, wbv, pop, push;
    ent_t e;
    reset = rst; wb_we = we; wb_wr = wr; wb_wd = wd;
    md_valid = mv; md_wr = mwr; md_wd = mwd; q1 = a; q2 = b;
    #1;
    e_stall = FAIR && (m_scnt == MAX_STARVE);
    wbv     = !rst && we && (wr != 5'd0) && !e_stall;
    if (wbv && m_pend(wr)) begin
      nfail++;
      $error("FAIL hazard: WB write to pending register %0d", wr);
    end
    chk("md_ready",   md_ready,   (!rst && mq.size() < DEPTH));
    chk("fifo_count", fifo_count, mq.size());
    chk("wb_stall",   wb_stall,   e_stall);
    chk("q1_pend",    q1_pend,    m_pend(a));
    chk("q2_pend",    q2_pend,    m_pend(b));
    chk("rf_write",   rf_write,   m_write);
    chk("rf_wr",      rf_wr,      m_wr);
    chk("rf_wd",      rf_wd,      m_wd);
    if (rst) begin
      mq.delete();
      m_write = 1'b0; m_wr = '0; m_wd = '0; m_scnt = 0;
    end else begin
      pop  = !wbv && mq.size() > 0;
      push = mv && mq.size() < DEPTH && mwr != 5'd0;
      if (e_stall || pop || mq.size() == 0) m_scnt = 0;
      else if (wbv) m_scnt++;
      if (wbv) begin
        m_write = 1'b1; m_wr = wr; m_wd = wd;
      end else if (pop) begin
        m_write = 1'b1; m_wr = mq[0].wr; m_wd = mq[0].wd;
      end else begin
        m_write = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.wr = mwr; e.wd = mwd;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        r_we, r_mv, r_rst;
    logic [4:0]  r_wr, r_mwr;

    reset = 1'b1; wb_we = 1'b0; wb_wr = '0; wb_wd = '0;
    md_valid = 1'b0; md_wr = '0; md_wd = '0; q1 = '0; q2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    step(1, 0, 0, 0, 1, 3, 32'h1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // WB write to r5, then WB request to r0 (ignored)
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single multi-cycle result with WB idle, watch pending on r9
    step(0, 0, 0, 0, 1, 9, 32'h1234, 9, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 9, 9);

    // fill FIFO while WB writes every cycle; 5th push refused; then drain
    for (int i = 0; i < 5; i++)
      step(0, 1, 5'(20 + i), 32'hA000 + i, 1, 5'(10 + i), 32'hB000 + i, 5'(10 + i), 13);
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 10, 13);

    // build count 2, then push while popping over 10 rounds (pointer wrap)
    step(0, 1, 25, 32'h25, 1, 1, 32'hC000, 1, 2);
    step(0, 1, 26, 32'h26, 1, 2, 32'hC001, 1, 2);
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 0, 1, 5'(1 + (i % 7)), 32'hC100 + i, 5'(1 + (i % 7)), 3);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 2);

    // reset with 3 entries queued; nothing stale afterwards
    for (int i = 0; i < 3; i++)
      step(0, 1, 5'(27 + i), 32'hD0 + i, 1, 5'(15 + i), 32'hE0 + i, 15, 16);
    step(1, 0, 0, 0, 1, 4, 32'hF0, 15, 16);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 15, 17);

    // FIFO non-empty with WB writing every cycle (starvation window)
    step(0, 1, 1, 32'h100, 1, 30, 32'h3030, 30, 0);
    for (int i = 0; i < 11; i++)
      step(0, 1, 5'(2 + i), 32'h200 + i, 0, 0, 0, 30, 5'(2 + i));
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 30, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 255) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_wr  = 5'($urandom_range(0, 15));
      if (m_pend(r_wr)) r_we = 1'b0;
      r_mv  = $urandom_range(0, 9) < 6;
      r_mwr = 5'($urandom_range(0, 7));
      step(r_rst, r_we, r_wr, $urandom, r_mv, r_mwr, $urandom,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Writer-side front end for the 32x32 register file write port (write/wr/wd). Merges two result sources into the single port:
  - the in-order pipeline WB stage;
  - the multi-cycle multiply/divide unit, buffered in a small FIFO.
- Drives the register-file write port from a registered output stage.
- Exposes a pending-write scoreboard so decode can stall on registers whose results have not yet reached the register file.

Parameters:
- DEPTH, 4: FIFO entries for multi-cycle results; power of two, 2..16.
- CW, 3: width of fifo_count; must hold values 0..DEPTH.
- MAX_STARVE, 8: consecutive WB-won cycles before forced drain; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_we  in  1  WB stage write request
- wb_wr  in  5  WB destination register
- wb_wd  in  32  WB write data
- md_valid  in  1  multi-cycle result valid
- md_ready  out  1  FIFO can accept a result
- md_wr  in  5  multi-cycle destination register
- md_wd  in  32  multi-cycle result data
- rf_write  out  1  to register-file write
- rf_wr  out  5  to register-file wr
- rf_wd  out  32  to register-file wd
- q1  in  5  scoreboard query register 1 (decode rs)
- q2  in  5  scoreboard query register 2 (decode rt)
- q1_pend  out  1  q1 has a write in flight
- q2_pend  out  1  q2 has a write in flight
- fifo_count  out  CW  number of queued entries
- wb_stall  out  1  pipeline must hold WB this cycle

Behaviour:
- Reset: Clock is clk. Reset is synchronous and active-high.
  - Values at reset: rf_write=0, rf_wr=0, rf_wd=0, FIFO empty, fifo_count=0, starvation counter=0, wb_stall=0.
  - md_ready=0 while reset is high.
  - Reset in mid-operation discards all queued entries and any staged write.
- WB validity: a WB write is valid when wb_we=1, wb_wr!=0, and wb_stall=0.
- Handshake: md_ready = !reset and fifo_count<DEPTH. This is combinational from state. When the FIFO is full, no push is accepted, even in a cycle where a pop occurs.
- Push: occurs when md_valid and md_ready are both 1.
  - md_wr=0: the result is accepted and discarded, not enqueued.
- Arbitration, evaluated each cycle:
  - A valid WB write wins.
  - Otherwise, if the FIFO is non-empty, the head entry is popped.
  - Otherwise nothing is issued.
- Output stage: the winner is registered into rf_write/rf_wr/rf_wd on the next clk edge. Latency is 1 cycle from the win to the output, and the register file commits on the edge after that. When nothing wins, rf_write=0 and rf_wr/rf_wd hold their previous values.
- Simultaneous push and pop: allowed; fifo_count is unchanged. A push into an empty FIFO cannot pop in the same cycle (minimum 1 cycle of queue residency).
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally. Order is strictly FIFO.
- Scoreboard: qN_pend=1 if qN!=0 and qN matches either of:
  - any valid FIFO entry's wr;
  - the staged rf_wr while rf_write=1.
  
  This is combinational. q=0 never reports pending.
- Ordering hazard: the pipeline must not issue a WB write to a register that is pending. Violation is a protocol error and the bench asserts on it. The block performs no reordering.
- Without the optional feature: wb_stall is tied 0, and a full FIFO can be starved indefinitely by back-to-back WB writes.

Optional Feature:
- Macro: WB_FAIR_ARB_EN.
- Defined:
  - The starvation counter increments on every cycle where a valid WB write wins while the FIFO is non-empty.
  - It clears on a pop or when the FIFO is empty.
  - When the counter equals MAX_STARVE, wb_stall=1 for one cycle, the FIFO head is popped, and the counter clears.
- Not defined: the counter logic is absent and wb_stall is constant 0.

Test Plan:
- Reset, then WB write wb_wr=5, wb_wd=0xDEADBEEF -> next cycle rf_write=1, rf_wr=5, rf_wd=0xDEADBEEF. Same stimulus with wb_wr=0 -> rf_write stays 0.
- Push md_wr=9, md_wd=0x1234 with WB idle -> fifo_count=1 for 1 cycle, q1=9 gives q1_pend=1; the following cycle rf_write=1 with rf_wr=9; q1_pend drops after the staged write retires.
- Fill the FIFO with 4 pushes while WB writes every cycle -> md_ready=0 at count 4; 5th md_valid not accepted; WB idle -> drains 4 entries in push order on consecutive cycles.
- Push while popping at count 2 -> count stays 2; 10 push/pop rounds exercise pointer wrap with data order preserved.
- Assert reset with 3 entries queued -> fifo_count=0, rf_write=0, no stale writes issued after release.
- With WB_FAIR_ARB_EN: FIFO non-empty, WB writes every cycle -> wb_stall=1 on the 9th cycle and the head entry is issued; without the macro, wb_stall is never 1.
